// File: rtl/complex_multiplier_axis.sv
// Pipelined signed complex multiplier (A*B) with valid-only AXI-Stream ports and fixed latency.
// Optional macro CMULT_ROUND_EN adds round-half-up before the output slice.
module complex_multiplier_axis #(
  parameter int OPERAND_WIDTH_A   = 16,
  parameter int OPERAND_WIDTH_B   = 16,
  parameter int OPERAND_WIDTH_OUT = 16,
  parameter int STAGES            = 6,
  parameter int BLOCKING          = 0,
  parameter int GROWTH_BITS       = -2
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [2*OPERAND_WIDTH_A-1:0]   s_axis_a_tdata,
  input  logic                           s_axis_a_tvalid,
  input  logic [2*OPERAND_WIDTH_B-1:0]   s_axis_b_tdata,
  input  logic                           s_axis_b_tvalid,
  output logic [2*OPERAND_WIDTH_OUT-1:0] m_axis_dout_tdata,
  output logic                           m_axis_dout_tvalid
);
  localparam int WA    = OPERAND_WIDTH_A;
  localparam int WB    = OPERAND_WIDTH_B;
  localparam int WO    = OPERAND_WIDTH_OUT;
  localparam int P     = WA + WB + 1;
  localparam int SHIFT = WA + WB - WO + 1 + GROWTH_BITS;
  // The slice may reach above the full-precision sum, so widen to cover it.
  localparam int EW    = (SHIFT + WO > P) ? SHIFT + WO : P;

`ifdef CMULT_ROUND_EN
  localparam logic signed [EW-1:0] RND =
    (SHIFT > 0) ? ({{(EW-1){1'b0}}, 1'b1} << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`else
  localparam logic signed [EW-1:0] RND = '0;
`endif

  logic                      issue_s;
  logic [2*WA-1:0]           a_sel_s;
  logic [2*WB-1:0]           b_sel_s;
  logic signed [WA-1:0]      ar_q, ai_q;
  logic signed [WB-1:0]      br_q, bi_q;
  logic signed [WA+WB-1:0]   p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic signed [EW-1:0]      pr_s, pi_s;
  logic [2*WO-1:0]           slice_s, out_src_s, out_q;
  logic [STAGES:1]           vld_q;

  generate
    if (BLOCKING != 0) begin : g_hold
      logic [2*WA-1:0] a_hold_q, a_hold_d;
      logic [2*WB-1:0] b_hold_q, b_hold_d;
      logic            a_pend_q, a_pend_d, a_pend_s;
      logic            b_pend_q, b_pend_d, b_pend_s;

      // Pairing: a fresh beat bypasses the hold register, both pendings clear on issue
      always_comb begin
        a_pend_s = s_axis_a_tvalid | a_pend_q;
        b_pend_s = s_axis_b_tvalid | b_pend_q;
        a_sel_s  = s_axis_a_tvalid ? s_axis_a_tdata : a_hold_q;
        b_sel_s  = s_axis_b_tvalid ? s_axis_b_tdata : b_hold_q;
        issue_s  = a_pend_s & b_pend_s;
        a_hold_d = a_sel_s;
        b_hold_d = b_sel_s;
        a_pend_d = issue_s ? 1'b0 : a_pend_s;
        b_pend_d = issue_s ? 1'b0 : b_pend_s;
      end

      always_ff @(posedge aclk) begin
        if (!aresetn) begin
          a_hold_q <= '0;
          b_hold_q <= '0;
          a_pend_q <= 1'b0;
          b_pend_q <= 1'b0;
        end else begin
          a_hold_q <= a_hold_d;
          b_hold_q <= b_hold_d;
          a_pend_q <= a_pend_d;
          b_pend_q <= b_pend_d;
        end
      end
    end else begin : g_direct
      assign a_sel_s = s_axis_a_tdata;
      assign b_sel_s = s_axis_b_tdata;
      assign issue_s = s_axis_a_tvalid & s_axis_b_tvalid;
    end
  endgenerate

  // Stage 1 captures operands, stage 2 forms the four partial products
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ar_q   <= '0;
      ai_q   <= '0;
      br_q   <= '0;
      bi_q   <= '0;
      p_rr_q <= '0;
      p_ii_q <= '0;
      p_ri_q <= '0;
      p_ir_q <= '0;
      vld_q  <= '0;
    end else begin
      ar_q   <= $signed(a_sel_s[WA-1:0]);
      ai_q   <= $signed(a_sel_s[2*WA-1:WA]);
      br_q   <= $signed(b_sel_s[WB-1:0]);
      bi_q   <= $signed(b_sel_s[2*WB-1:WB]);
      p_rr_q <= (WA+WB)'(ar_q) * (WA+WB)'(br_q);
      p_ii_q <= (WA+WB)'(ai_q) * (WA+WB)'(bi_q);
      p_ri_q <= (WA+WB)'(ar_q) * (WA+WB)'(bi_q);
      p_ir_q <= (WA+WB)'(ai_q) * (WA+WB)'(br_q);
      vld_q  <= {vld_q[STAGES-1:1], issue_s};
    end
  end

  // Stage 3 arithmetic: cross-term add/sub, optional rounding, rescale by bit slice
  always_comb begin
    pr_s    = EW'(p_rr_q) - EW'(p_ii_q) + RND;
    pi_s    = EW'(p_ri_q) + EW'(p_ir_q) + RND;
    slice_s = {WO'(pi_s >>> SHIFT), WO'(pr_s >>> SHIFT)};
  end

  generate
    if (STAGES > 3) begin : g_dly
      logic [2*WO-1:0] dly_q [STAGES-3];

      always_ff @(posedge aclk) begin
        if (!aresetn) begin
          for (int i = 0; i < STAGES - 3; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= slice_s;
          for (int i = 1; i < STAGES - 3; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign out_src_s = dly_q[STAGES-4];
    end else begin : g_nodly
      assign out_src_s = slice_s;
    end
  endgenerate

  // Output register only loads on a valid product so tdata holds between beats
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_q <= '0;
    end else if (vld_q[STAGES-1]) begin
      out_q <= out_src_s;
    end else begin
      out_q <= out_q;
    end
  end

  assign m_axis_dout_tdata  = out_q;
  assign m_axis_dout_tvalid = vld_q[STAGES];
endmodule

// File: tb/tb_complex_multiplier_axis.sv
// Directed bench for complex_multiplier_axis: a non-blocking and a blocking instance share stimulus.
module tb_complex_multiplier_axis;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] a_data, b_data;
  logic        a_valid, b_valid;
  logic [31:0] dout0, dout1;
  logic        vld0, vld1;
  int          checks = 0;
  int          errors = 0;

  always #5 aclk = ~aclk;

  complex_multiplier_axis #(.BLOCKING(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_a_tdata(a_data), .s_axis_a_tvalid(a_valid),
    .s_axis_b_tdata(b_data), .s_axis_b_tvalid(b_valid),
    .m_axis_dout_tdata(dout0), .m_axis_dout_tvalid(vld0)
  );

  complex_multiplier_axis #(.BLOCKING(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_a_tdata(a_data), .s_axis_a_tvalid(a_valid),
    .s_axis_b_tdata(b_data), .s_axis_b_tvalid(b_valid),
    .m_axis_dout_tdata(dout1), .m_axis_dout_tvalid(vld1)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision complex product, floor-shifted by 15, low 16 bits kept.
  function automatic logic [31:0] cmul(input logic [31:0] a, input logic [31:0] b);
    longint ar, ai, br, bi, pr, pi;
    ar = longint'($signed(a[15:0]));
    ai = longint'($signed(a[31:16]));
    br = longint'($signed(b[15:0]));
    bi = longint'($signed(b[31:16]));
    pr = ar * br - ai * bi;
    pi = ar * bi + ai * br;
`ifdef CMULT_ROUND_EN
    pr = pr + 64'sd16384;
    pi = pi + 64'sd16384;
`endif
    pr = pr >>> 15;
    pi = pi >>> 15;
    return {pi[15:0], pr[15:0]};
  endfunction

  function automatic logic [31:0] beat_a(input int i);
    logic [15:0] r, m;
    r = 16'(i * 131 - 16000);
    m = 16'(9000 - i * 97);
    return {m, r};
  endfunction

  function automatic logic [31:0] beat_b(input int i);
    logic [15:0] r, m;
    r = 16'(32767 - i * 211);
    m = 16'(i * 53 - 7000);
    return {m, r};
  endfunction

  // One beat on both channels; result expected exactly 6 edges after capture, then held.
  task automatic run_single(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
    a_data = a; b_data = b; a_valid = 1'b1; b_valid = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      check({tag, "_vld0"}, {31'd0, vld0}, {31'd0, (t == 6)});
      check({tag, "_vld1"}, {31'd0, vld1}, {31'd0, (t == 6)});
      if (t >= 6) begin
        check({tag, "_dat0"}, dout0, exp);
        check({tag, "_dat1"}, dout1, exp);
      end
    end
  endtask

  initial begin
    logic [31:0] lat_exp;
    aresetn = 1'b0; a_data = '0; b_data = '0; a_valid = 1'b0; b_valid = 1'b0;
    step(); step(); step();
    check("rst_vld0", {31'd0, vld0}, 32'd0);
    check("rst_dat0", dout0, 32'd0);
    check("rst_vld1", {31'd0, vld1}, 32'd0);
    check("rst_dat1", dout1, 32'd0);
    aresetn = 1'b1;
    step();

`ifdef CMULT_ROUND_EN
    lat_exp = 32'h0000_4000;
`else
    lat_exp = 32'h0000_3FFF;
`endif
    run_single("latency", 32'h0000_4000, 32'h0000_7FFF, lat_exp);
    run_single("jj",      32'h4000_0000, 32'h4000_0000, 32'h0000_E000);
    run_single("mixed",   32'h1000_2000, 32'h2000_1000, 32'h0A00_0000);
    run_single("wrap",    32'h0000_8000, 32'h0000_8000, 32'h0000_8000);

    // 256 back-to-back beats: continuous valid from edge 6 through edge 261, in order
    for (int t = 0; t <= 263; t++) begin
      if (t >= 1) begin
        check("strm_vld0", {31'd0, vld0}, {31'd0, (t >= 6 && t <= 261)});
        check("strm_vld1", {31'd0, vld1}, {31'd0, (t >= 6 && t <= 261)});
        if (t >= 6 && t <= 261) begin
          check("strm_dat0", dout0, cmul(beat_a(t - 6), beat_b(t - 6)));
          check("strm_dat1", dout1, cmul(beat_a(t - 6), beat_b(t - 6)));
        end
      end
      a_valid = (t < 256); b_valid = (t < 256);
      a_data = beat_a(t); b_data = beat_b(t);
      step();
    end

    // Reset for one edge mid-stream: nothing captured before it may emerge afterwards
    for (int t = 0; t <= 25; t++) begin
      if (t >= 1) begin
        check("mrst_vld0", {31'd0, vld0}, {31'd0, (t >= 6 && t <= 10)});
        check("mrst_vld1", {31'd0, vld1}, {31'd0, (t >= 6 && t <= 10)});
        if (t >= 6 && t <= 10) begin
          check("mrst_dat0", dout0, cmul(beat_a(t - 6 + 500), beat_b(t - 6 + 500)));
        end
        if (t >= 11) begin
          check("mrst_zero0", dout0, 32'd0);
          check("mrst_zero1", dout1, 32'd0);
        end
      end
      a_valid = (t <= 10); b_valid = (t <= 10);
      a_data = beat_a(t + 500); b_data = beat_b(t + 500);
      aresetn = (t != 10);
      step();
    end
    aresetn = 1'b1;

    // A at cycles 0 and 1 (second overwrites), B at cycle 3: blocking pairs, non-blocking drops
    for (int t = 0; t <= 13; t++) begin
      if (t >= 1) begin
        check("blk_vld1", {31'd0, vld1}, {31'd0, (t == 9)});
        check("lone_vld0", {31'd0, vld0}, 32'd0);
        check("lone_dat0", dout0, 32'd0);
        if (t >= 9) begin
          check("blk_dat1", dout1, 32'h0A00_0000);
        end
      end
      a_valid = (t == 0 || t == 1);
      a_data  = (t == 0) ? 32'h0000_7FFF : 32'h1000_2000;
      b_valid = (t == 3);
      b_data  = 32'h2000_1000;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
